// File: rtl/count_extender_if.sv
// Bundle between the mod-16 up/down counter and its high-order extender.
// The master drives direction and the low count; the slave returns the extended count and flags.
interface count_extender_if #(
    parameter int HIGH_WIDTH = 4
);
    logic                    enable;
    logic [3:0]              low_count;
    logic [HIGH_WIDTH+3:0]   ext_count;
    logic                    carry;
    logic                    borrow;
    logic                    overflow;
    logic                    underflow;
    logic                    step_error;

    modport master (
        output enable, low_count,
        input  ext_count, carry, borrow, overflow, underflow, step_error
    );

    modport slave (
        input  enable, low_count,
        output ext_count, carry, borrow, overflow, underflow, step_error
    );
endinterface

// File: rtl/count_extender.sv
// Extends a 4-bit up/down ripple counter with a HIGH_WIDTH-bit high count by
// watching its wraps; also flags illegal low-count steps and high-count range wraps.
module count_extender #(
    parameter int HIGH_WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    count_extender_if.slave  bus
);
    localparam logic [HIGH_WIDTH-1:0] HIGH_ONES = '1;

    logic [3:0]             prev_low_q, prev_low_d;
    logic                   prev_dir_q, prev_dir_d;
    logic                   primed_q, primed_d;
    logic [HIGH_WIDTH-1:0]  high_q, high_d;
    logic [HIGH_WIDTH+3:0]  ext_q, ext_d;
    logic                   carry_q, carry_d;
    logic                   borrow_q, borrow_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   err_q, err_d;
    logic [3:0]             delta;
    logic [3:0]             exp_step;

    always_comb begin
        prev_low_d = bus.low_count;
        prev_dir_d = bus.enable;
        primed_d   = 1'b1;
        high_d     = high_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        err_d      = err_q;
        delta      = bus.low_count - prev_low_q;
        exp_step   = prev_dir_q ? 4'd1 : 4'd15;

        // The step is judged against the direction the counter used to make it,
        // which is the direction sampled on the previous edge.
        if (primed_q && delta != 4'd0) begin
            if (delta == exp_step) begin
                if (prev_dir_q && prev_low_q == 4'd15 && bus.low_count == 4'd0) begin
                    high_d  = high_q + 1'b1;
                    carry_d = 1'b1;
                    if (high_q == HIGH_ONES) ovf_d = 1'b1;
                end else if (!prev_dir_q && prev_low_q == 4'd0 && bus.low_count == 4'd15) begin
                    high_d   = high_q - 1'b1;
                    borrow_d = 1'b1;
                    if (high_q == '0) unf_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        ext_d = {high_d, bus.low_count};
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            prev_low_q <= '0;
            prev_dir_q <= 1'b0;
            primed_q   <= 1'b0;
            high_q     <= '0;
            ext_q      <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_low_q <= prev_low_d;
            prev_dir_q <= prev_dir_d;
            primed_q   <= primed_d;
            high_q     <= high_d;
            ext_q      <= ext_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            err_q      <= err_d;
        end
    end

    assign bus.ext_count  = ext_q;
    assign bus.carry      = carry_q;
    assign bus.borrow     = borrow_q;
    assign bus.overflow   = ovf_q;
    assign bus.underflow  = unf_q;
    assign bus.step_error = err_q;
endmodule

// File: tb/tb_count_extender.sv
// Directed-vector bench for count_extender with HIGH_WIDTH=4 (8-bit extended count).
module tb_count_extender;
    localparam int HW = 4;

    logic clock;
    logic clear;
    int   n_vec;
    int   n_err;
    int   n_carry;

    count_extender_if #(.HIGH_WIDTH(HW)) bus ();

    count_extender #(.HIGH_WIDTH(HW)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ext, input logic c, input logic b,
                           input logic o, input logic u, input logic e);
        chk({tag, ".ext"}, 32'(bus.ext_count), 32'(ext));
        chk({tag, ".carry"}, 32'(bus.carry), 32'(c));
        chk({tag, ".borrow"}, 32'(bus.borrow), 32'(b));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(o));
        chk({tag, ".unf"}, 32'(bus.underflow), 32'(u));
        chk({tag, ".err"}, 32'(bus.step_error), 32'(e));
    endtask

    // Apply inputs, take one rising edge, then settle 1 time unit past it.
    task automatic step(input logic [3:0] lo, input logic en);
        bus.low_count = lo;
        bus.enable    = en;
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(4'd0, 1'b1);
        clear = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear = 1'b1;
        bus.low_count = 4'd0;
        bus.enable    = 1'b1;

        // Reset for two cycles
        step(4'd0, 1'b1);
        step(4'd0, 1'b1);
        chk_all("reset", 8'h00, 0, 0, 0, 0, 0);
        clear = 1'b0;

        // Up-count 0..15,0,1: carry on the 15->0 step
        step(4'd0, 1'b1);
        chk_all("up_unprimed", 8'h00, 0, 0, 0, 0, 0);
        for (int i = 1; i < 16; i++) begin
            step(4'(i), 1'b1);
            chk("up_ext", 32'(bus.ext_count), 32'(i));
            chk("up_nocarry", 32'(bus.carry), 32'd0);
        end
        step(4'd0, 1'b1);
        chk_all("up_wrap", 8'h10, 1, 0, 0, 0, 0);
        step(4'd1, 1'b1);
        chk_all("up_after", 8'h11, 0, 0, 0, 0, 0);

        // Down through 0->15: direction changes on a hold edge
        step(4'd1, 1'b0);
        chk_all("dn_hold", 8'h11, 0, 0, 0, 0, 0);
        step(4'd0, 1'b0);
        chk_all("dn_to0", 8'h10, 0, 0, 0, 0, 0);
        step(4'd15, 1'b0);
        chk_all("dn_wrap", 8'h0F, 0, 1, 0, 0, 0);
        step(4'd14, 1'b0);
        chk_all("dn_after", 8'h0E, 0, 0, 0, 0, 0);

        // 256 up-steps: high count wraps, overflow sticky, 16 carries
        do_clear();
        step(4'd0, 1'b1);
        n_carry = 0;
        for (int i = 0; i < 256; i++) begin
            step(4'((i + 1) % 16), 1'b1);
            if (bus.carry) n_carry++;
            chk("ovf_ext", 32'(bus.ext_count), 32'((i + 1) % 256));
            if (i == 254) chk("ovf_before", 32'(bus.overflow), 32'd0);
        end
        chk_all("ovf_wrap", 8'h00, 1, 0, 1, 0, 0);
        chk("ovf_carries", 32'(n_carry), 32'd16);
        step(4'd1, 1'b1);
        chk_all("ovf_sticky", 8'h01, 0, 0, 1, 0, 0);

        // Underflow: 0 -> 15 with high count at zero
        do_clear();
        step(4'd0, 1'b0);
        step(4'd15, 1'b0);
        chk_all("unf_wrap", 8'hFF, 0, 1, 0, 1, 0);

        // Illegal jump 3 -> 7, then counting resumes with sticky error
        do_clear();
        step(4'd3, 1'b1);
        chk_all("jump_unprimed", 8'h03, 0, 0, 0, 0, 0);
        step(4'd7, 1'b1);
        chk_all("jump", 8'h07, 0, 0, 0, 0, 1);
        step(4'd8, 1'b1);
        chk_all("jump_resume", 8'h08, 0, 0, 0, 0, 1);

        // 15 -> 0 while previous direction was down: error, no carry
        do_clear();
        step(4'd15, 1'b0);
        step(4'd0, 1'b1);
        chk_all("rev_wrap", 8'h00, 0, 0, 0, 0, 1);

        // Direction toggled between valid steps 5->6 (up), 6->5 (down)
        do_clear();
        step(4'd5, 1'b1);
        step(4'd6, 1'b0);
        chk_all("tog_up", 8'h06, 0, 0, 0, 0, 0);
        step(4'd5, 1'b0);
        chk_all("tog_dn", 8'h05, 0, 0, 0, 0, 0);

        // Clear coincident with a 15->0 step at 0x2F
        do_clear();
        step(4'd0, 1'b1);
        for (int i = 1; i <= 47; i++) step(4'(i % 16), 1'b1);
        chk_all("pre_clr", 8'h2F, 0, 0, 0, 0, 0);
        clear = 1'b1;
        step(4'd0, 1'b1);
        chk_all("clr_wrap", 8'h00, 0, 0, 0, 0, 0);
        clear = 1'b0;
        step(4'd5, 1'b1);
        chk_all("clr_unprimed", 8'h05, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
